network_bank_xbar: RTL and testbench
====================================

Name: network_bank_xbar

Overview:
Parametrised, pipelined N-lane crossbar that permutes bank addresses (or coefficient words) between N memory banks in the mixed-radix NTT datapath. Next generation of the fixed 4-lane 7-bit combinational address network: any power-of-two lane count and any width, gather or scatter mode, a valid/ready elastic pipeline, and permutation-conflict detection. Sits between the address generator and the bank RAMs, or between the RAMs and the butterfly units.

Parameters:
N_LANES, 4, lane/bank count; power of two, >=2
DATA_W, 7, width of each lane word
SEL_W, $clog2(N_LANES), per-lane select width (derived; do not override)
PIPE_STAGES, 2, register stages from input to output; >=1
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts a beat this cycle
mode  in  1  0 = gather (out[i] = in[sel[i]]), 1 = scatter (out[sel[i]] = in[i]); sampled with the beat
data_in  in  N_LANES*DATA_W  lane words; lane i at bits [i*DATA_W +: DATA_W]
sel_in  in  N_LANES*SEL_W  per-lane selects; lane i at [i*SEL_W +: SEL_W]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
data_out  out  N_LANES*DATA_W  permuted lane words, same packing as data_in
conflict  out  1  beat at output had a non-permutation select vector
conflict_cnt  out  CNT_W  saturating count of conflicted beats accepted

Behaviour:
- Reset (rst=1 at an edge): all stage valid bits clear, data_out=0, conflict=0, out_valid=0, conflict_cnt=0. Reset mid-transfer drops every in-flight beat; no output follows. in_ready is 0 while rst=1.
- Handshake: a beat transfers at input when in_valid && in_ready, and at output when out_valid && out_ready. in_valid/data_in/sel_in/mode must be held until accepted. out_valid/data_out/conflict stay stable while out_valid && !out_ready.
- Pipeline: PIPE_STAGES stages, each holding a valid bit, payload and conflict bit. Stage k advances when stage k+1 is empty or advancing; the final stage advances on out_ready. in_ready = stage 0 empty or advancing (combinational from out_ready through the chain; bubbles collapse). Throughput is one beat per cycle when out_ready=1.
- Latency: a beat accepted at edge t is presented at out_valid after edge t+PIPE_STAGES-1 (PIPE_STAGES=1: visible the cycle after acceptance) when there is no back-pressure.
- Permutation: computed combinationally ahead of stage 0 and registered into stage 0; later stages only delay.
- Gather: out[i] = in[sel[i]]. Conflict if any two lanes share a select value; the data is still produced as defined.
- Scatter: out[j] = in[i] for the lowest i with sel[i]=j. Outputs with no writer are 0. Conflict if any two lanes share a select value (equivalently, some output has no writer).
- conflict_cnt increments by 1 at each input acceptance whose beat is conflicted; it saturates at all-ones and clears only on rst.
- Simultaneous input accept and output release in the same cycle is legal and loses nothing.

Decomposition:
- Shared package ntt_net_pkg: lane-index helper functions (pack/unpack lane slice), a SEL_W derivation function, and MODE_GATHER=1'b0 and MODE_SCATTER=1'b1 constants.
- One sub-module, network_perm_core: purely combinational gather/scatter mux plus conflict detection, with parameters N_LANES and DATA_W. The top level holds the elastic pipeline and the counter.

Test Plan:
- N=4, DATA_W=7, gather, data={3:0x33,2:0x22,1:0x11,0:0x00}, sel={0,1,2,3} (lane3..0), out_ready=1 -> after 2 edges, data_out={0x00,0x11,0x22,0x33}, conflict=0, conflict_cnt=0.
- Scatter, same data, sel={0,0,1,2} (lane3..0) -> out[2]=0x00, out[0]=0x22 (lowest-index writer is lane2), out[1]=0x11, out[3]=0, conflict=1, conflict_cnt=1.
- Back-pressure: stream 5 identity beats with out_ready held 0 -> exactly PIPE_STAGES beats accepted, in_ready=0 afterwards, data_out stable; then out_ready=1 -> all 5 beats emerge in order with no loss or duplication.
- Full throughput: 16 consecutive beats with in_valid=1 and out_ready=1 -> 16 outputs on 16 consecutive cycles, each matching a golden model.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight and conflict_cnt=3 -> out_valid=0, conflict_cnt=0 on the next cycle, and no stale beat appears afterwards.
- Saturation with CNT_W=2: send 5 conflicted beats -> conflict_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/ntt_net_pkg.sv
// Shared definitions for the NTT bank network: mode encodings, select-width
// derivation and lane slice index helpers.
package ntt_net_pkg;

  localparam logic MODE_GATHER  = 1'b0;
  localparam logic MODE_SCATTER = 1'b1;

  // Width of a per-lane select for a given lane count (never less than 1).
  function automatic int sel_width(input int n_lanes);
    return (n_lanes <= 2) ? 1 : $clog2(n_lanes);
  endfunction

  // Low bit of lane `lane` in a vector packed with `w`-bit lanes.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // High bit of lane `lane` in a vector packed with `w`-bit lanes.
  function automatic int lane_hi(input int lane, input int w);
    return lane * w + w - 1;
  endfunction

endpackage

// File: rtl/network_perm_core.sv
// Combinational lane permutation: gather (out[i] = in[sel[i]]) or scatter
// (out[sel[i]] = in[i], lowest writer wins, unwritten lanes zero), plus a
// flag raised when the select vector is not a permutation.
module network_perm_core
  import ntt_net_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 7
) (
  input  logic                                   mode,
  input  logic [N_LANES*DATA_W-1:0]              data_in,
  input  logic [N_LANES*sel_width(N_LANES)-1:0]  sel_in,
  output logic [N_LANES*DATA_W-1:0]              data_out,
  output logic                                   conflict
);

  localparam int SEL_W = sel_width(N_LANES);

  // Duplicate selects mean the vector is not a permutation.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      for (int j = i + 1; j < N_LANES; j++) begin
        if (sel_in[lane_lo(i, SEL_W) +: SEL_W] == sel_in[lane_lo(j, SEL_W) +: SEL_W])
          conflict = 1'b1;
      end
    end
  end

  // Lane mux; scatter scans writers from the top down so the lowest index lands last.
  always_comb begin
    data_out = '0;
    if (mode == MODE_GATHER) begin
      for (int i = 0; i < N_LANES; i++) begin
        for (int j = 0; j < N_LANES; j++) begin
          if (sel_in[lane_lo(i, SEL_W) +: SEL_W] == SEL_W'(j))
            data_out[lane_lo(i, DATA_W) +: DATA_W] = data_in[lane_lo(j, DATA_W) +: DATA_W];
        end
      end
    end else begin
      for (int j = 0; j < N_LANES; j++) begin
        for (int i = N_LANES - 1; i >= 0; i--) begin
          if (sel_in[lane_lo(i, SEL_W) +: SEL_W] == SEL_W'(j))
            data_out[lane_lo(j, DATA_W) +: DATA_W] = data_in[lane_lo(i, DATA_W) +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/network_bank_xbar.sv
// Pipelined N-lane bank crossbar with valid/ready elastic stages and a
// saturating counter of conflicted (non-permutation) beats.
module network_bank_xbar
  import ntt_net_pkg::*;
#(
  parameter int N_LANES     = 4,
  parameter int DATA_W      = 7,
  parameter int SEL_W       = sel_width(N_LANES),
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        mode,
  input  logic [N_LANES*DATA_W-1:0]   data_in,
  input  logic [N_LANES*SEL_W-1:0]    sel_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_LANES*DATA_W-1:0]   data_out,
  output logic                        conflict,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int WORD_W = N_LANES * DATA_W;
  localparam int LAST   = PIPE_STAGES - 1;

  logic [WORD_W-1:0]      perm_data;
  logic                   perm_conflict;
  logic [PIPE_STAGES-1:0] vld_p;
  logic [PIPE_STAGES-1:0] rdy;
  logic [WORD_W-1:0]      data_p [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] conflict_p;
  logic                   accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  network_perm_core #(
    .N_LANES (N_LANES),
    .DATA_W  (DATA_W)
  ) u_perm (
    .mode     (mode),
    .data_in  (data_in),
    .sel_in   (sel_in),
    .data_out (perm_data),
    .conflict (perm_conflict)
  );

  // Per-stage load enable: a stage may take new data when empty or draining,
  // chained back from out_ready so bubbles collapse.
  always_comb begin
    logic r;
    rdy       = '0;
    r         = !vld_p[LAST] || out_ready;
    rdy[LAST] = r;
    for (int k = LAST - 1; k >= 0; k--) begin
      r      = !vld_p[k] || r;
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0] && !rst;
  assign accept   = in_valid && in_ready;

  // Stage valid bits and the conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p        <= '0;
      conflict_cnt <= '0;
    end else begin
      // stage 0: permuted beat enters
      if (rdy[0]) vld_p[0] <= in_valid;
      // stages 1..LAST: delay only
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (rdy[k]) vld_p[k] <= vld_p[k-1];
      end
      if (accept && perm_conflict) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  // Stage payloads; validity is carried by vld_p, so no reset is needed here.
  always_ff @(posedge clk) begin
    // stage 0: registered permutation result
    if (rdy[0]) begin
      data_p[0]     <= perm_data;
      conflict_p[0] <= perm_conflict;
    end
    // stages 1..LAST: delay only
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (rdy[k]) begin
        data_p[k]     <= data_p[k-1];
        conflict_p[k] <= conflict_p[k-1];
      end
    end
  end

  assign out_valid = vld_p[LAST];
  assign data_out  = vld_p[LAST] ? data_p[LAST] : '0;
  assign conflict  = vld_p[LAST] && conflict_p[LAST];

endmodule

// File: tb/tb_network_bank_xbar.sv
// Self-checking bench for network_bank_xbar (N=4, DATA_W=7, 2 stages, 2-bit counter).
module tb_network_bank_xbar;

  localparam int N        = 4;
  localparam int DW       = 7;
  localparam int SW       = 2;
  localparam int STAGES   = 2;
  localparam int CW       = 2;
  localparam int WORD_W   = N * DW;
  localparam int SEL_BITS = N * SW;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic [WORD_W-1:0] data_in;
  logic [SEL_BITS-1:0] sel_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] data_out;
  logic              conflict;
  logic [CW-1:0]     conflict_cnt;

  int checks   = 0;
  int failures = 0;
  int outs_seen = 0;
  logic [CW-1:0] cnt_model = '0;
  logic [WORD_W:0] sb [$];

  network_bank_xbar #(
    .N_LANES     (N),
    .DATA_W      (DW),
    .PIPE_STAGES (STAGES),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode         (mode),
    .data_in      (data_in),
    .sel_in       (sel_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Golden model: returns {data, conflict}.
  function automatic logic [WORD_W:0] model(input logic m, input logic [WORD_W-1:0] d,
                                            input logic [SEL_BITS-1:0] s);
    logic [WORD_W-1:0] o;
    logic c;
    int hits [N];
    o = '0;
    c = 1'b0;
    for (int j = 0; j < N; j++) hits[j] = 0;
    for (int i = 0; i < N; i++) hits[int'(s[i*SW +: SW])]++;
    for (int j = 0; j < N; j++) if (hits[j] != 1) c = 1'b1;
    if (m == 1'b0) begin
      for (int i = 0; i < N; i++) o[i*DW +: DW] = d[int'(s[i*SW +: SW])*DW +: DW];
    end else begin
      for (int j = 0; j < N; j++) begin
        bit found = 0;
        for (int i = 0; i < N; i++) begin
          if (!found && int'(s[i*SW +: SW]) == j) begin
            o[j*DW +: DW] = d[i*DW +: DW];
            found = 1;
          end
        end
      end
    end
    return {o, c};
  endfunction

  // Scoreboard: push expected on input accept, pop/compare on output release.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      cnt_model = '0;
    end else begin
      if (out_valid && out_ready) begin
        logic [WORD_W:0] exp;
        outs_seen++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_beat got=%h,%b exp=none", data_out, conflict);
        end else begin
          exp = sb.pop_front();
          if ({data_out, conflict} !== exp) begin
            failures++;
            $display("FAIL sb_beat got=%h,%b exp=%h,%b", data_out, conflict,
                     exp[WORD_W:1], exp[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        logic [WORD_W:0] e;
        e = model(mode, data_in, sel_in);
        sb.push_back(e);
        if (e[0] && cnt_model != '1) cnt_model = cnt_model + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [WORD_W-1:0] d, input logic [SEL_BITS-1:0] s);
    bit done = 0;
    mode = m; data_in = d; sel_in = s; in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout got=not_accepted exp=accepted");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
    checks++; if (conflict_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gather();
    send(1'b0, {7'h33, 7'h22, 7'h11, 7'h00}, {2'd0, 2'd1, 2'd2, 2'd3});
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gather_latency_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gather_latency got=%b exp=1", out_valid); end
    checks++; if (data_out !== {7'h00, 7'h11, 7'h22, 7'h33}) begin failures++; $display("FAIL gather_data got=%h exp=%h", data_out, {7'h00, 7'h11, 7'h22, 7'h33}); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL gather_conflict got=%b exp=0", conflict); end
    checks++; if (conflict_cnt !== 2'd0) begin failures++; $display("FAIL gather_cnt got=%0d exp=0", conflict_cnt); end
    repeat (3) tick();
  endtask

  task automatic test_scatter();
    send(1'b1, {7'h33, 7'h22, 7'h11, 7'h00}, {2'd0, 2'd0, 2'd1, 2'd2});
    checks++; if (conflict_cnt !== 2'd1) begin failures++; $display("FAIL scatter_cnt got=%0d exp=1", conflict_cnt); end
    tick();
    checks++; if (data_out !== {7'h00, 7'h00, 7'h11, 7'h22}) begin failures++; $display("FAIL scatter_data got=%h exp=%h", data_out, {7'h00, 7'h00, 7'h11, 7'h22}); end
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL scatter_conflict got=%b exp=1", conflict); end
    repeat (3) tick();
  endtask

  task automatic test_back_pressure();
    logic [WORD_W-1:0] beats [5];
    int idx = 0;
    int outs0;
    for (int b = 0; b < 5; b++) beats[b] = WORD_W'($urandom);
    out_ready = 1'b0; mode = 1'b0; sel_in = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 5); data_in = beats[(idx < 5) ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
    end
    checks++; if (idx != STAGES) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", idx, STAGES); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (data_out !== beats[0] || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h,%b exp=%h,1", data_out, out_valid, beats[0]); end
    outs0 = outs_seen;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (idx < 5); data_in = beats[(idx < 5) ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (outs_seen - outs0 != 5) begin failures++; $display("FAIL bp_out_count got=%0d exp=5", outs_seen - outs0); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok_rdy = 1;
    int nout = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        mode     = 1'($urandom_range(0, 1));
        data_in  = WORD_W'($urandom);
        sel_in   = SEL_BITS'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 16 && !in_ready) ok_rdy = 0;
      if (c >= 2 && out_valid) nout++;
      tick();
    end
    checks++; if (!ok_rdy) begin failures++; $display("FAIL b2b_in_ready got=stall exp=no_stall"); end
    checks++; if (nout != 16) begin failures++; $display("FAIL b2b_out_cycles got=%0d exp=16", nout); end
    checks++; if (conflict_cnt !== cnt_model) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", conflict_cnt, cnt_model); end
    repeat (3) tick();
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) send(1'b0, WORD_W'($urandom), '0);
    checks++; if (conflict_cnt !== 2'd3) begin failures++; $display("FAIL mid_cnt_pre got=%0d exp=3", conflict_cnt); end
    repeat (3) tick();
    out_ready = 1'b0;
    send(1'b0, WORD_W'($urandom), '0);
    send(1'b1, WORD_W'($urandom), '0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_in_flight got=%b exp=1", out_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (conflict_cnt !== 2'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", conflict_cnt); end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      tick();
    end
    checks++; if (seen) begin failures++; $display("FAIL mid_stale got=beat exp=none"); end
  endtask

  task automatic test_saturation();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      send(1'b1, WORD_W'($urandom), {2'd1, 2'd1, 2'd3, 2'd0});
      checks++;
      if (conflict_cnt !== CW'(exp_cnt[b])) begin
        failures++;
        $display("FAIL sat_cnt_%0d got=%0d exp=%0d", b, conflict_cnt, exp_cnt[b]);
      end
    end
    repeat (4) tick();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sat_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 1'b0; data_in = '0; sel_in = '0;
    test_reset();
    test_gather();
    test_scatter();
    test_back_pressure();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
